// File: rtl/mips_mem_pkg.sv
// Shared definitions for the lw/sw data-memory path: word size, wait counter
// width, responder state encoding and the load/store opcodes.
package mips_mem_pkg;

    localparam int WORD_BITS = 32;
    localparam int CNT_BITS  = 4;

    // Opcodes the control decoder maps onto memRead/memWrite.
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mem_state_e;

    function automatic logic word_aligned(input logic [1:0] byte_off);
        return byte_off == 2'b00;
    endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port word array: synchronous write, combinational read of the same index.
module mem_array_sp
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        idx_i,
    input  logic [WORD_BITS-1:0] wdata_i,
    output logic [WORD_BITS-1:0] rdata_o
);

    // Contents survive reset on purpose; software expects data to persist.
    logic [WORD_BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder for lw/sw: latches a request, waits LATENCY cycles,
// then returns a one-cycle memReady pulse (with memError for rejected accesses).
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_BITS   = 8,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 memRead,
    input  logic                 memWrite,
    input  logic [WORD_BITS-1:0] address,
    input  logic [WORD_BITS-1:0] writeData,
    output logic [WORD_BITS-1:0] readData,
    output logic                 memReady,
    output logic                 memError
);

    // Handshake: a request (exactly one of memRead/memWrite) is taken on an IDLE
    // edge and held by the requester until it sees memReady=1 for one cycle;
    // memError qualifies that same pulse and readData is nonzero only with it.

    mem_state_e state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic [WORD_BITS-1:0] wdata_q, wdata_d;
    logic                 is_write_q, is_write_d;
    logic [WORD_BITS-1:0] rdata_q, rdata_d;
    logic                 ready_q, ready_d;
    logic                 error_q, error_d;

    logic                 req_valid;
    logic                 req_conflict;
    logic                 req_misaligned;
    logic [ADDR_BITS-1:0] in_idx;

    logic                 arr_we;
    logic [ADDR_BITS-1:0] arr_idx;
    logic [WORD_BITS-1:0] arr_wdata;
    logic [WORD_BITS-1:0] arr_rdata;

    // High address bits alias onto the array by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[WORD_BITS-1:ADDR_BITS+2];

    assign req_valid      = memRead ^ memWrite;
    assign req_conflict   = memRead & memWrite;
    assign req_misaligned = !word_aligned(address[1:0]);
    assign in_idx         = address[ADDR_BITS+1:2];

    // In IDLE the array looks at the live bus so a zero-latency access can
    // complete on the accepting edge; otherwise it uses the latched copies.
    assign arr_idx   = (state_q == IDLE) ? in_idx : idx_q;
    assign arr_wdata = (state_q == IDLE) ? writeData : wdata_q;

    mem_array_sp #(
        .DEPTH (DEPTH_WORDS),
        .AW    (ADDR_BITS)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .idx_i   (arr_idx),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        rdata_d    = '0;
        ready_d    = 1'b0;
        error_d    = 1'b0;
        arr_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_conflict || (req_valid && req_misaligned)) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                end else if (req_valid) begin
                    idx_d      = in_idx;
                    wdata_d    = writeData;
                    is_write_d = memWrite;
                    cnt_d      = CNT_BITS'(LATENCY);
                    if (LATENCY == 0) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        arr_we  = memWrite;
                        rdata_d = memWrite ? '0 : arr_rdata;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end

            BUSY: begin
                if (cnt_q <= CNT_BITS'(1)) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    arr_we  = is_write_q;
                    rdata_d = is_write_q ? '0 : arr_rdata;
                end else begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign readData = rdata_q;
    assign memReady = ready_q;
    assign memError = error_q;

endmodule
